// File: rtl/polyvec_barrett_reduce_lanes_if.sv
// polyvec_barrett_reduce_lanes_if: start/busy/done handshake plus flattened input/output vector buses
interface polyvec_barrett_reduce_lanes_if #(
   parameter int VEC_W = 8192
);
   logic             start;
   logic             busy;
   logic             done;
   logic [VEC_W-1:0] iPolyVec;
   logic [VEC_W-1:0] oPolyVec;
   modport master (output start, iPolyVec, input busy, done, oPolyVec);
   modport slave  (input start, iPolyVec, output busy, done, oPolyVec);
endinterface

// File: rtl/polyvec_barrett_reduce_lanes.sv
// polyvec_barrett_reduce_lanes: LANES-wide 2-stage Barrett reduce over a KYBER_K polyvec; POLY_REDUCE_CANONICAL_EN gives [0,Q-1] output
module polyvec_barrett_reduce_lanes #(
   parameter int KYBER_K   = 2,
   parameter int KYBER_N   = 256,
   parameter int KYBER_Q   = 3329,
   parameter int COEFF_W   = 16,
   parameter int LANES     = 4,
   parameter int BARRETT_V = 20159,
   parameter int VEC_W     = COEFF_W*KYBER_K*KYBER_N
) (
   input logic clk,
   input logic reset,
   polyvec_barrett_reduce_lanes_if.slave bus
);
   localparam int B  = KYBER_K*KYBER_N/LANES;
   localparam int CW = B > 1 ? $clog2(B) : 1;

   if ((KYBER_K*KYBER_N) % LANES != 0) begin : g_lanes_chk
      $error("LANES must divide KYBER_K*KYBER_N");
   end

   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

   state_t                    state_q, state_d;
   logic [CW-1:0]             cnt_q, cnt_d;
   logic [CW-1:0]             s1_beat_q, s1_beat_d;
   logic                      s1_valid_q, s1_valid_d;
   logic                      done_q, done_d;
   logic signed [COEFF_W-1:0] s1_a_q [LANES];
   logic signed [COEFF_W-1:0] s1_a_d [LANES];
   logic signed [31:0]        s1_prod_q [LANES];
   logic signed [31:0]        s1_prod_d [LANES];
   logic signed [COEFF_W-1:0] r [LANES];
   logic [VEC_W-1:0]          out_q, out_d;

   assign bus.busy     = state_q != IDLE;
   assign bus.done     = done_q;
   assign bus.oPolyVec = out_q;

   // Control: issue one beat per cycle, then one drain cycle for the last stage-2 write
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      s1_valid_d = 1'b0;
      s1_beat_d  = cnt_q;
      done_d     = 1'b0;
      case (state_q)
         IDLE:  state_d = bus.start ? ISSUE : IDLE;
         ISSUE: begin
            s1_valid_d = 1'b1;
            cnt_d      = cnt_q == CW'(B-1) ? '0 : cnt_q + 1'b1;
            state_d    = cnt_q == CW'(B-1) ? DRAIN : ISSUE;
         end
         DRAIN: begin
            state_d = IDLE;
            done_d  = 1'b1;
         end
         default: state_d = IDLE;
      endcase
   end

   // Datapath: stage 1 forms the rounded Barrett product, stage 2 subtracts t*Q into the beat's output slots
   always_comb begin
      out_d = out_q;
      for (int l = 0; l < LANES; l++) begin
         s1_a_d[l]    = bus.iPolyVec[VEC_W-1-(int'(cnt_q)*LANES+l)*COEFF_W -: COEFF_W];
         s1_prod_d[l] = 32'(s1_a_d[l]) * 32'(BARRETT_V) + 32'(1 << 25);
         r[l]         = COEFF_W'(32'(s1_a_q[l]) - (s1_prod_q[l] >>> 26) * 32'(KYBER_Q));
`ifdef POLY_REDUCE_CANONICAL_EN
         r[l]         = r[l] < 0 ? r[l] + COEFF_W'(KYBER_Q) : r[l];
`else
         r[l]         = r[l];
`endif
         if (s1_valid_q) out_d[VEC_W-1-(int'(s1_beat_q)*LANES+l)*COEFF_W -: COEFF_W] = r[l];
      end
   end

   // State, pipeline and output registers; reset clears everything without a done pulse
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         s1_beat_q  <= '0;
         s1_valid_q <= 1'b0;
         done_q     <= 1'b0;
         out_q      <= '0;
         for (int l = 0; l < LANES; l++) begin
            s1_a_q[l]    <= '0;
            s1_prod_q[l] <= '0;
         end
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         s1_beat_q  <= s1_beat_d;
         s1_valid_q <= s1_valid_d;
         done_q     <= done_d;
         out_q      <= out_d;
         for (int l = 0; l < LANES; l++) begin
            s1_a_q[l]    <= s1_a_d[l];
            s1_prod_q[l] <= s1_prod_d[l];
         end
      end
   end
endmodule

// File: tb/tb_polyvec_barrett_reduce_lanes.sv
// tb_polyvec_barrett_reduce_lanes: directed and random runs checked against a modular-arithmetic reference model
module tb_polyvec_barrett_reduce_lanes;
   localparam int Q   = 3329;
   localparam int NC  = 512;
   localparam int VW  = NC*16;
   localparam int LAT = NC/4 + 1;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int checks = 0;
   int errors = 0;
   logic [15:0] coef [NC];
   logic [15:0] vals [6] = '{16'd3329, 16'd1664, 16'd1665, 16'hFFFF, 16'h7FFF, 16'h8000};
   int lat;
   int pulses;

   polyvec_barrett_reduce_lanes_if #(.VEC_W(VW)) bus ();

   polyvec_barrett_reduce_lanes dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] ref_red(input logic [15:0] a);
      int m;
      m = $signed(a);
      m = m % Q;
      if (m < 0) m += Q;
`ifndef POLY_REDUCE_CANONICAL_EN
      if (m > (Q-1)/2) m -= Q;
`endif
      return 16'(m);
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   task automatic load_vec();
      for (int c = 0; c < NC; c++) bus.iPolyVec[VW-1-c*16 -: 16] = coef[c];
   endtask

   task automatic check_vec(input string tag);
      for (int c = 0; c < NC; c++)
         chk($sformatf("%s_coef%0d", tag, c), 32'(bus.oPolyVec[VW-1-c*16 -: 16]), 32'(ref_red(coef[c])));
   endtask

   task automatic rand_vec();
      for (int c = 0; c < NC; c++) coef[c] = 16'($urandom);
      load_vec();
   endtask

   task automatic run(input string tag, input bit extra, output int l);
      bus.start = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      l = 0;
      chk({tag, "_busy_rise"}, 32'(bus.busy), 1);
      while (l < 1000) begin
         bus.start = extra && (l == 4 || l == 99);
         @(posedge clk);
         #1;
         l++;
         if (bus.done) break;
         if (!bus.busy) chk({tag, "_busy_gap"}, 32'(bus.busy), 1);
      end
      bus.start = 1'b0;
      chk({tag, "_latency"}, 32'(l), 32'(LAT));
      chk({tag, "_busy_fall"}, 32'(bus.busy), 0);
   endtask

   initial begin
      bus.start = 1'b0;
      bus.iPolyVec = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", 32'(bus.busy), 0);
      chk("rst_done", 32'(bus.done), 0);
      chk("rst_out", 32'(bus.oPolyVec === '0), 1);
      reset = 1'b0;
      @(posedge clk);
      #1;

      for (int c = 0; c < NC; c++) coef[c] = vals[c % 6];
      load_vec();
      run("dir", 1'b0, lat);
      check_vec("dir");

      @(posedge clk);
      #1;
      for (int c = 0; c < NC; c++) coef[c] = 16'(c);
      load_vec();
      run("ramp", 1'b0, lat);
      check_vec("ramp");

      @(posedge clk);
      #1;
      rand_vec();
      run("extra", 1'b1, lat);
      check_vec("extra");
      pulses = 0;
      repeat (20) begin
         @(posedge clk);
         #1;
         if (bus.done || bus.busy) pulses++;
      end
      chk("extra_no_requeue", 32'(pulses), 0);

      rand_vec();
      run("b2b_a", 1'b0, lat);
      check_vec("b2b_a");
      rand_vec();
      run("b2b_b", 1'b0, lat);
      check_vec("b2b_b");

      @(posedge clk);
      #1;
      rand_vec();
      bus.start = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      repeat (59) @(posedge clk);
      #1;
      reset = 1'b1;
      #1;
      chk("mrst_busy", 32'(bus.busy), 0);
      chk("mrst_done", 32'(bus.done), 0);
      chk("mrst_out", 32'(bus.oPolyVec === '0), 1);
      repeat (2) @(posedge clk);
      #1;
      chk("mrst_busy_hold", 32'(bus.busy), 0);
      chk("mrst_out_hold", 32'(bus.oPolyVec === '0), 1);
      reset = 1'b0;
      @(posedge clk);
      #1;
      chk("mrst_no_done", 32'(bus.done), 0);
      rand_vec();
      run("post_rst", 1'b0, lat);
      check_vec("post_rst");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
